// File: rtl/arbitro_rr.sv
// Round-robin pop scheduler: eight source FIFOs share one datapath that feeds
// four destination FIFOs. Each popped word is routed to the destination named by its top two bits.
module arbitro_rr #(
    parameter int DATA_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [7:0]              empty_fifo,
    input  logic [8*DATA_WIDTH-1:0] data_in,
    input  logic [3:0]              almost_full_out,
    output logic [7:0]              pop,
    output logic [3:0]              push,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [2:0]              grant_id,
    output logic                    idle
);

    typedef enum logic [1:0] {IDLE, ACTIVE, PAUSE} state_t;

    state_t                state;
    logic [2:0]            ptr;
    logic [2:0]            sel;
    logic [2:0]            idx;
    logic [2:0]            pop_idx;
    logic [2:0]            cap_idx;
    logic                  cap_vld;
    logic                  found;
    logic                  any_elig;
    logic                  do_pop;
    logic [7:0]            elig;
    logic [DATA_WIDTH-1:0] cap_word;

    // The empty flag lags a pop by one cycle, so the source being popped now is masked.
    assign elig     = ~empty_fifo & ~pop;
    assign any_elig = |elig;
    assign do_pop   = enable & ~(|almost_full_out) & any_elig;

    // Search starts just after the pointer; ptr itself is the last candidate.
    always_comb begin
        sel   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && elig[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        pop_idx = '0;
        for (int i = 0; i < 8; i++)
            if (pop[i]) pop_idx = 3'(i);
    end

    assign cap_word = data_in[cap_idx*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= 3'd7;
            pop      <= '0;
            grant_id <= '0;
            cap_vld  <= 1'b0;
            cap_idx  <= '0;
            push     <= '0;
            data_out <= '0;
        end else begin
            pop <= do_pop ? (8'b1 << sel) : 8'b0;
            if (do_pop) begin
                ptr      <= sel;
                grant_id <= sel;
            end
            // Words already popped always drain; backpressure only stops new pops.
            cap_vld <= |pop;
            cap_idx <= pop_idx;
            push    <= cap_vld ? (4'b1 << cap_word[DATA_WIDTH-1 -: 2]) : 4'b0;
            if (cap_vld) data_out <= cap_word;

            case (state)
                IDLE:    if (enable && any_elig) state <= ACTIVE;
                ACTIVE:  if (!enable || !any_elig) state <= IDLE;
                         else if (|almost_full_out) state <= PAUSE;
                PAUSE:   if (!enable || !any_elig) state <= IDLE;
                         else if (!(|almost_full_out)) state <= ACTIVE;
                default: state <= IDLE;
            endcase
        end
    end

    assign idle = ~(|pop) & ~cap_vld & ~(|push);

endmodule

// File: tb/tb_arbitro_rr.sv
// Bench for arbitro_rr: directed scenarios plus random traffic, checked every
// cycle against a cycle-level reference model of the scheduling rules.
module tb_arbitro_rr;
    localparam int DW = 10;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b0;
    logic [7:0]      empty_fifo = 8'hFF;
    logic [8*DW-1:0] data_in = '0;
    logic [3:0]      almost_full_out = '0;
    logic [7:0]      pop;
    logic [3:0]      push;
    logic [DW-1:0]   data_out;
    logic [2:0]      grant_id;
    logic            idle;

    arbitro_rr #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .empty_fifo(empty_fifo),
        .data_in(data_in), .almost_full_out(almost_full_out), .pop(pop),
        .push(push), .data_out(data_out), .grant_id(grant_id), .idle(idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [7:0]    m_pop;
    int            m_pop_idx;
    int            m_ptr;
    int            m_grant;
    bit            m_cap;
    int            m_cap_src;
    logic [3:0]    m_push;
    logic [DW-1:0] m_data;
    bit            force_cls;
    int            rot[4] = '{0, 3, 5, 7};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pop = '0; m_pop_idx = 0; m_ptr = 7; m_grant = 0;
        m_cap = 0; m_cap_src = 0; m_push = '0; m_data = '0;
    endtask

    task automatic rand_data();
        for (int i = 0; i < 8; i++) data_in[i*DW +: DW] = DW'($urandom);
        if (force_cls) data_in[2*DW+DW-1 -: 2] = 2'b01;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pop"}, 32'(pop), 0);
        chk({tag, "_push"}, 32'(push), 0);
        chk({tag, "_data"}, 32'(data_out), 0);
        chk({tag, "_grant"}, 32'(grant_id), 0);
        chk({tag, "_idle"}, 32'(idle), 1);
    endtask

    // One clock: model decides from the inputs present now, then outputs are compared after the edge.
    task automatic cycle();
        logic [7:0]    elig;
        int            sel;
        logic [DW-1:0] w;
        bit            m_idle;
        elig = ~empty_fifo & ~m_pop;
        sel = -1;
        if (enable && almost_full_out == 4'b0)
            for (int k = 1; k <= 8; k++)
                if (sel < 0 && elig[(m_ptr + k) % 8]) sel = (m_ptr + k) % 8;
        w = data_in[m_cap_src*DW +: DW];
        @(posedge clk);
        if (m_cap) begin
            m_push = 4'b1 << w[DW-1:DW-2];
            m_data = w;
        end else m_push = '0;
        m_cap = (m_pop != 0);
        m_cap_src = m_pop_idx;
        if (sel >= 0) begin
            m_pop = 8'b1 << sel; m_pop_idx = sel; m_ptr = sel; m_grant = sel;
        end else m_pop = '0;
        m_idle = (m_pop == 0) && !m_cap && (m_push == 0);
        #1;
        chk("pop", 32'(pop), 32'(m_pop));
        chk("push", 32'(push), 32'(m_push));
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("grant_id", 32'(grant_id), 32'(m_grant));
        chk("idle", 32'(idle), 32'(m_idle));
        rand_data();
    endtask

    initial begin
        bit prev;
        force_cls = 0;
        m_reset();
        rand_data();
        #2 chk_reset_outputs("rst");
        empty_fifo = 8'h00;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("rst_hold");
        @(negedge clk) reset = 1'b0;

        // rotation over sources 0,3,5,7
        empty_fifo = 8'b01010110;
        for (int i = 0; i < 9; i++) begin
            cycle();
            chk("rot_order", 32'(pop), 32'(8'b1 << rot[i % 4]));
        end

        // backpressure for 4 cycles, then release
        almost_full_out = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("bp_pop", 32'(pop), 0);
        end
        almost_full_out = 4'b0000;
        repeat (6) cycle();

        // single source with class 01
        force_cls = 1;
        empty_fifo = 8'b11111011;
        repeat (2) cycle();
        prev = m_pop[2];
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("single_toggle", 32'(pop[2]), 32'(!prev));
            prev = !prev;
        end
        force_cls = 0;

        // enable drop and recovery
        empty_fifo = 8'b01010110;
        repeat (4) cycle();
        enable = 1'b0;
        cycle();
        chk("en_drop_pop", 32'(pop), 0);
        repeat (2) cycle();
        chk("en_drop_idle", 32'(idle), 1);
        enable = 1'b1;
        repeat (6) cycle();

        // async reset between edges
        repeat (3) cycle();
        #2 reset = 1'b1;
        #1 chk_reset_outputs("async_rst");
        m_reset();
        #1 reset = 1'b0;
        cycle();
        chk("post_rst_first", 32'(pop), 32'h01);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            empty_fifo = 8'($urandom) | 8'($urandom);
            enable = ($urandom_range(0, 9) != 0);
            almost_full_out = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
